systolic_tile: RTL and testbench

//  Parametrised ROWS x COLS output-stationary systolic MAC tile with a built-in controller.

---
 rtl/systolic_tile.sv | 216 +++++++++++++++++++++
 tb/tb_systolic_tile.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_tile.sv
// Output-stationary ROWS x COLS systolic MAC tile with its own job controller:
// skewed operand entry, K-beat feed, flush, and a row-by-row valid/ready result drain.
module systolic_tile #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20,
    parameter int K_WIDTH    = 8,
    parameter int SIGNED     = 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic [K_WIDTH-1:0]                        k_len,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0]                a_in,
    input  logic [COLS*DATA_WIDTH-1:0]                b_in,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
    output logic [COLS*ACC_WIDTH-1:0]                 out_data,
    output logic                                      busy,
    output logic                                      done
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ACC_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int EW = (AW > PW) ? AW : PW;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FW = $clog2(ROWS + COLS + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN} state_t;

    state_t               state;
    logic [K_WIDTH-1:0]   k_reg;
    logic [K_WIDTH-1:0]   beat_cnt;
    logic [FW-1:0]        flush_cnt;
    logic                 beat;
    logic                 acc_clear;
    logic                 acc_en;

    logic [ROWS-1:0][DW-1:0]            a_edge;
    logic [COLS-1:0][DW-1:0]            b_edge;
    logic [ROWS-1:0][COLS-1:0][DW-1:0]  a_pe;
    logic [ROWS-1:0][COLS-1:0][DW-1:0]  b_pe;
    logic [ROWS-1:0][COLS-1:0][AW-1:0]  acc;

    // Full-width product, extended per SIGNED, then added modulo 2^AW.
    function automatic logic [AW-1:0] mac(input logic [AW-1:0] acc_v,
                                          input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [PW-1:0] ax, bx, p;
        if (SIGNED != 0) begin
            ax = PW'($signed(a));
            bx = PW'($signed(b));
            p  = ax * bx;
            return acc_v + AW'(EW'($signed(p)));
        end else begin
            ax = PW'(a);
            bx = PW'(b);
            p  = ax * bx;
            return acc_v + AW'(EW'(p));
        end
    endfunction

    assign beat      = in_valid && in_ready;
    assign acc_clear = (state == CLEAR);
    assign acc_en    = (state == FEED) || (state == FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k_reg     <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_row   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // The done cycle still belongs to the finishing job, so start is ignored there.
                    busy <= start && !done;
                    if (start && !done) begin
                        k_reg <= k_len;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    beat_cnt  <= '0;
                    flush_cnt <= '0;
                    if (k_reg == '0) begin
                        state <= FLUSH;
                    end else begin
                        state    <= FEED;
                        in_ready <= 1'b1;
                    end
                end
                FEED: begin
                    if (in_valid) begin
                        beat_cnt <= beat_cnt + K_WIDTH'(1);
                        if (beat_cnt == k_reg - K_WIDTH'(1)) begin
                            in_ready <= 1'b0;
                            state    <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + FW'(1);
                    if (flush_cnt == FW'(ROWS + COLS - 1)) begin
                        state     <= DRAIN;
                        out_valid <= 1'b1;
                        out_row   <= '0;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_row == RW'(ROWS - 1)) begin
                            out_valid <= 1'b0;
                            out_row   <= '0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            out_row <= out_row + RW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Skew stage: row r / column c enter the array r / c cycles late; non-beats inject zeros.
    for (genvar r = 0; r < ROWS; r++) begin : g_askew
        logic [DW-1:0] a_beat;
        assign a_beat = beat ? a_in[r*DW +: DW] : '0;
        if (r == 0) begin : g_direct
            assign a_edge[r] = a_beat;
        end else begin : g_sr
            logic [DW-1:0] sr [r];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < r; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= a_beat;
                    for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
                end
            end
            assign a_edge[r] = sr[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_bskew
        logic [DW-1:0] b_beat;
        assign b_beat = beat ? b_in[c*DW +: DW] : '0;
        if (c == 0) begin : g_direct
            assign b_edge[c] = b_beat;
        end else begin : g_sr
            logic [DW-1:0] sr [c];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < c; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= b_beat;
                    for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
                end
            end
            assign b_edge[c] = sr[c-1];
        end
    end

    // PE stage: operands registered once per PE, a flows right, b flows down.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_pe
            logic [DW-1:0] a_left, b_up, a_q, b_q;
            logic [AW-1:0] acc_q;
            if (c == 0) begin : g_al
                assign a_left = a_edge[r];
            end else begin : g_ai
                assign a_left = a_pe[r][c-1];
            end
            if (r == 0) begin : g_bt
                assign b_up = b_edge[c];
            end else begin : g_bi
                assign b_up = b_pe[r-1][c];
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    acc_q <= '0;
                end else begin
                    a_q <= a_left;
                    b_q <= b_up;
                    if (acc_clear)   acc_q <= '0;
                    else if (acc_en) acc_q <= mac(acc_q, a_q, b_q);
                end
            end
            assign a_pe[r][c] = a_q;
            assign b_pe[r][c] = b_q;
            assign acc[r][c]  = acc_q;
        end
    end

    // Drain stage: accumulators are frozen outside FEED/FLUSH, so the selected row is stable.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int c = 0; c < COLS; c++) out_data[c*AW +: AW] = acc[out_row][c];
        end
    end

endmodule

// File: tb/tb_systolic_tile.sv
// Bench for systolic_tile: default 4x4 build checked against a matrix-product model,
// plus two 2x2 builds (signed 20-bit and unsigned 8-bit wrap) with literal expectations.
module tb_systolic_tile;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, in_valid, out_ready;
    logic [7:0]  k_len;
    logic [31:0] a_in, b_in;
    logic        in_ready, out_valid, busy, done;
    logic [1:0]  out_row;
    logic [79:0] out_data;

    logic        s_start, s_valid, s_ordy;
    logic [7:0]  s_k;
    logic [15:0] s_a, s_b;
    logic        p_in_ready, p_out_valid, p_busy, p_done;
    logic [0:0]  p_out_row;
    logic [39:0] p_out_data;
    logic        w_in_ready, w_out_valid, w_busy, w_done;
    logic [0:0]  w_out_row;
    logic [15:0] w_out_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    systolic_tile dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_data(out_data), .busy(busy), .done(done));

    systolic_tile #(.ROWS(2), .COLS(2), .ACC_WIDTH(20), .SIGNED(1)) dut_p (
        .clk(clk), .rst_n(rst_n), .start(s_start), .k_len(s_k),
        .in_valid(s_valid), .in_ready(p_in_ready), .a_in(s_a), .b_in(s_b),
        .out_valid(p_out_valid), .out_ready(s_ordy), .out_row(p_out_row),
        .out_data(p_out_data), .busy(p_busy), .done(p_done));

    systolic_tile #(.ROWS(2), .COLS(2), .ACC_WIDTH(8), .SIGNED(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(s_start), .k_len(s_k),
        .in_valid(s_valid), .in_ready(w_in_ready), .a_in(s_a), .b_in(s_b),
        .out_valid(w_out_valid), .out_ready(s_ordy), .out_row(w_out_row),
        .out_data(w_out_data), .busy(w_busy), .done(w_done));

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the 4x4 job: the accepted beats, and C as a plain sum of products.
    int ma [64][4];
    int mb [64][4];
    int mk = 0;

    function automatic logic [19:0] model_c(input int r, input int c);
        longint s = 0;
        for (int k = 0; k < mk; k++) s += longint'(ma[k][r]) * longint'(mb[k][c]);
        return s[19:0];
    endfunction

    function automatic int aval(input int dsel, input int r, input int k);
        return (dsel == 0) ? (r + k + 1) : (100 - 30 * r);
    endfunction

    function automatic int bval(input int dsel, input int k, input int c);
        return (dsel == 0) ? (c - k) : (-100 + 7 * c);
    endfunction

    // Compare process: every drained row is checked against the model.
    logic [19:0] cap [4][4];
    int          exp_row = 0;
    logic        prev_last = 1'b0, prev_stall = 1'b0;
    logic [79:0] prev_data;
    logic [1:0]  prev_row;
    int          irdy_total = 0;

    always @(negedge clk) begin
        if (in_ready) irdy_total++;
        if (!rst_n) begin
            exp_row    = 0;
            prev_last  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("done", done, prev_last);
            if (out_valid) begin
                chk("out_row", out_row, exp_row);
                for (int c = 0; c < 4; c++) begin
                    chk("c_elem", out_data[c*20 +: 20], model_c(exp_row, c));
                    cap[exp_row][c] = out_data[c*20 +: 20];
                end
                if (prev_stall)
                    chk("stall_hold", (out_data == prev_data && out_row == prev_row), 1);
            end
            prev_last  = out_valid && out_ready && (exp_row == 3);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_row   = out_row;
            if (out_valid && out_ready) exp_row = (exp_row + 1) % 4;
        end
    end

    task automatic run_job(input int k, input logic [15:0] vmask, input int vlen,
                           input bit toggle, input int dsel, input int abort_after,
                           input int exp_done_cyc);
        int bi = 0, step = 0, guard = 0, ones = 0, exp_feed = 0, cyc = 0, irdy0;
        bit v, got = 0;
        mk = 0;
        while (ones < k) begin
            v = (exp_feed < vlen) ? vmask[exp_feed] : 1'b1;
            if (v) ones++;
            exp_feed++;
        end
        irdy0 = irdy_total;
        out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        k_len = 8'(k);
        @(posedge clk); #1;
        start = 1'b0;
        while (bi < k && guard < 200) begin
            if (bi == abort_after) begin
                rst_n = 1'b0;
                #1;
                chk("abort_busy", busy, 0);
                chk("abort_in_ready", in_ready, 0);
                chk("abort_out_valid", out_valid, 0);
                @(posedge clk); #1;
                rst_n    = 1'b1;
                in_valid = 1'b0;
                return;
            end
            v = (step < vlen) ? vmask[step] : 1'b1;
            in_valid = v;
            if (v) begin
                for (int r = 0; r < 4; r++) a_in[r*8 +: 8] = 8'(aval(dsel, r, bi));
                for (int c = 0; c < 4; c++) b_in[c*8 +: 8] = 8'(bval(dsel, bi, c));
            end else begin
                a_in = $urandom;
                b_in = $urandom;
            end
            @(negedge clk);
            if (in_ready) begin
                if (v) begin
                    for (int r = 0; r < 4; r++) ma[bi][r] = aval(dsel, r, bi);
                    for (int c = 0; c < 4; c++) mb[bi][c] = bval(dsel, bi, c);
                    bi++;
                    mk = bi;
                end
                step++;
            end
            @(posedge clk); #1;
            guard++;
        end
        if (bi < k) chk("feed_timeout", bi, k);
        in_valid = 1'b0;
        a_in = $urandom;
        b_in = $urandom;
        while (!got && cyc < 300) begin
            out_ready = toggle ? cyc[0] : 1'b1;
            @(negedge clk);
            if (cyc == 0) chk("busy_running", busy, 1);
            got = done;
            if (!got) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("done_seen", got, 1);
        chk("in_ready_cycles", irdy_total - irdy0, exp_feed);
        // Done lands after CLEAR, ROWS+COLS flush cycles and ROWS drain handshakes.
        if (exp_done_cyc >= 0) chk("done_latency", cyc, exp_done_cyc);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("busy_after_done", busy, 0);
    endtask

    logic [39:0] pc [2];
    logic [15:0] wc [2];
    int          prow [2];

    task automatic run_small(input logic [15:0] a0, input logic [15:0] b0,
                             input logic [15:0] a1, input logic [15:0] b1);
        int bi = 0, guard = 0, n = 0;
        bit got = 0;
        s_ordy = 1'b0;
        @(posedge clk); #1;
        s_start = 1'b1;
        s_k = 8'd2;
        @(posedge clk); #1;
        s_start = 1'b0;
        while (bi < 2 && guard < 50) begin
            s_valid = 1'b1;
            s_a = (bi == 0) ? a0 : a1;
            s_b = (bi == 0) ? b0 : b1;
            @(negedge clk);
            if (p_in_ready) bi++;
            @(posedge clk); #1;
            guard++;
        end
        s_valid = 1'b0;
        s_ordy  = 1'b1;
        guard   = 0;
        while (!got && guard < 100) begin
            @(negedge clk);
            if (p_out_valid && n < 2) begin
                pc[n]   = p_out_data;
                wc[n]   = w_out_data;
                prow[n] = int'(p_out_row);
                n++;
            end
            got = p_done;
            @(posedge clk); #1;
            guard++;
        end
        chk("small_done_seen", got, 1);
        chk("small_rows_drained", n, 2);
        @(negedge clk);
        chk("small_done_width", p_done, 0);
        chk("small_busy_idle", p_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        k_len = '0; a_in = '0; b_in = '0;
        s_start = 1'b0; s_valid = 1'b0; s_ordy = 1'b0; s_k = '0; s_a = '0; s_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_data_zero", (out_data == '0), 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;

        // 2x2 signed: A = I, B = [[1,2],[3,4]] gives C = B.
        run_small({8'd0, 8'd1}, {8'd2, 8'd1}, {8'd1, 8'd0}, {8'd4, 8'd3});
        chk("t1_row0_idx", prow[0], 0);
        chk("t1_row1_idx", prow[1], 1);
        chk("t1_c00", pc[0][19:0], 1);
        chk("t1_c01", pc[0][39:20], 2);
        chk("t1_c10", pc[1][19:0], 3);
        chk("t1_c11", pc[1][39:20], 4);

        // Unsigned 8-bit accumulator: 2*255*255 mod 256 = 2; signed build sees (-1)*(-1)*2 = 2.
        run_small(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        for (int r = 0; r < 2; r++) begin
            chk("t3_wrap_c0", wc[r][7:0], 2);
            chk("t3_wrap_c1", wc[r][15:8], 2);
            chk("t3_signed_c0", pc[r][19:0], 2);
        end

        // 4x4: A(r,k)=r+k+1, B(k,c)=c-k, K=4, in_valid high throughout.
        run_job(4, 16'hFFFF, 16, 1'b0, 0, -1, -1);
        chk("t2_model_c00", model_c(0, 0), 20'hFFFEC);
        chk("t2_model_c33", model_c(3, 3), 28);
        chk("t2_model_c03", model_c(0, 3), 10);
        chk("t2_c00", cap[0][0], 20'hFFFEC);
        chk("t2_c33", cap[3][3], 28);
        chk("t2_c21", cap[2][1], 20'hFFFF2);

        // Bubbles 1,0,0,1,1,0,1 and a toggling out_ready give the same C.
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) cap[r][c] = 20'h55555;
        run_job(4, 16'h0059, 7, 1'b1, 0, -1, -1);
        chk("t4_c00", cap[0][0], 20'hFFFEC);
        chk("t4_c33", cap[3][3], 28);
        chk("t4_c03", cap[0][3], 10);

        // k_len = 0: all zero; done after 1 + (4+4) + 4 cycles from the start edge.
        run_job(0, 16'h0000, 0, 1'b0, 0, -1, 13);
        chk("t5_c12", cap[1][2], 0);
        chk("t5_c33", cap[3][3], 0);

        // Reset during FEED after two beats of large operands, then a clean job.
        run_job(4, 16'hFFFF, 16, 1'b0, 1, 2, -1);
        run_job(4, 16'hFFFF, 16, 1'b0, 0, -1, -1);
        chk("t6_c00", cap[0][0], 20'hFFFEC);
        chk("t6_c21", cap[2][1], 20'hFFFF2);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
